slow_memory_master: RTL
=======================

SLOW_MEMORY_MASTER -- requirements
Module: slow_memory_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the memory and request addresses in bits.
REQ-002 Parameter DATA_WIDTH, default 32, width of the data word in bits.
REQ-003 Parameter FIFO_DEPTH, default 2, number of request queue entries; it is a power of two and at least 2.
REQ-004 Parameter TIMEOUT_CYCLES, default 15, maximum number of WAIT cycles before an error response.
REQ-005 Port clk, input, 1, clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, reset, asynchronous, active-high.
REQ-007 Port req_valid, input, 1, CPU request present.
REQ-008 Port req_ready, output, 1, queue can accept a request.
REQ-009 Port req_write, input, 1, 1 = write, 0 = read.
REQ-010 Port req_addr, input, ADDR_WIDTH, byte address.
REQ-011 Port req_wdata, input, DATA_WIDTH, write data.
REQ-012 Port resp_valid, output, 1, response present.
REQ-013 Port resp_ready, input, 1, CPU accepts the response.
REQ-014 Port resp_rdata, output, DATA_WIDTH, read data; 0 for writes and errors.
REQ-015 Port resp_err, output, 1, misaligned address or timeout.
REQ-016 Port mem_start, output, 1, begin memory operation.
REQ-017 Port mem_rdy, input, 1, memory idle or operation complete.
REQ-018 Port mem_write_enable, output, 1, memory write strobe.
REQ-019 Port mem_address, output, ADDR_WIDTH, memory address.
REQ-020 Port mem_data, inout, DATA_WIDTH, bidirectional memory data bus.

Function
REQ-021 The block SHALL accept a request into the FIFO on req_valid & req_ready, with req_ready = !full; a pop in the same cycle does not raise req_ready.
REQ-022 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, and process one request at a time from the FIFO head.
REQ-023 In IDLE with the FIFO non-empty, the FSM SHALL go to RESP with resp_err=1 if the head address bits [1:0] != 0 (no memory access); otherwise it SHALL go to ISSUE.
REQ-024 In ISSUE, mem_start SHALL equal mem_rdy; when mem_rdy=1 the FSM SHALL go to WAIT and clear the timeout counter; otherwise it SHALL stay in ISSUE.
REQ-025 mem_start SHALL be 0 in every state other than ISSUE, so it is never high when mem_rdy returns.
REQ-026 In ISSUE and WAIT, mem_address and mem_write_enable SHALL be driven from the FIFO head and held stable; in all other states they SHALL be 0.
REQ-027 mem_data SHALL be driven with head wdata only in ISSUE and WAIT of a write; at all other times it SHALL be high-impedance.
REQ-028 In WAIT, mem_rdy=1 SHALL capture mem_data into resp_rdata for reads (0 for writes) and move to RESP with resp_err=0.
REQ-029 In WAIT, the counter SHALL increment each cycle; on reaching TIMEOUT_CYCLES with mem_rdy=0, the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-030 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be stable; on resp_ready the FIFO SHALL pop and the FSM SHALL return to IDLE.
REQ-031 Read timing SHALL be: accepted in cycle 0, IDLE cycle 1, mem_start cycle 2, mem_rdy low cycles 3-7, captured cycle 8, resp_valid from cycle 9.
REQ-032 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a count register of log2(FIFO_DEPTH)+1 bits distinguishing full from empty.

Reset
REQ-033 Reset SHALL immediately force the FSM to IDLE, empty the FIFO, drive req_ready=1 and resp_valid=0, set resp_rdata, resp_err, mem_start, mem_write_enable and mem_address to 0, and release mem_data to high-impedance.
REQ-034 Reset during ISSUE or WAIT SHALL abandon the in-flight operation without a response.

Verification
REQ-035 Read 0x10 (memory holds 0xDEADBEEF) -> mem_start high only in cycle 2, resp_valid cycle 9, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-036 Write 0x20 with 0x12345678, then read 0x20 -> write resp_rdata=0; mem_data driven only during the write; read returns 0x12345678.
REQ-037 Read at 0x13 -> resp_err=1, resp_rdata=0, mem_start never asserted.
REQ-038 Three back-to-back requests with resp_ready=0 -> req_ready=0 after two accepted; third accepted only after the first response pops.
REQ-039 mem_rdy held low -> resp_err=1 after 15 WAIT cycles; mem_start stays 0 after ISSUE.
REQ-040 Reset asserted in WAIT -> all outputs at reset values in the same cycle, mem_data=Z, FIFO empty, no response issued.

Source files
------------

// File: rtl/slow_memory_master.sv
`default_nettype none
// ============================================================================
// Module   : slow_memory_master
// Purpose  : Bridges a valid/ready CPU request/response interface to a slow
//            handshake memory (mem_start / mem_rdy) with a bidirectional data
//            bus. Requests are queued in a small FIFO and executed one at a
//            time. Misaligned addresses and memory timeouts return an error
//            response.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   clock, all state updates on the rising edge
//   reset            in   asynchronous active-high reset
//   req_valid        in   CPU request present
//   req_ready        out  queue can accept a request
//   req_write        in   1 = write, 0 = read
//   req_addr         in   byte address
//   req_wdata        in   write data
//   resp_valid       out  response present
//   resp_ready       in   CPU accepts the response
//   resp_rdata       out  read data (0 for writes and errors)
//   resp_err         out  misaligned address or timeout
//   mem_start        out  begin memory operation
//   mem_rdy          in   memory idle or operation complete
//   mem_write_enable out  memory write strobe
//   mem_address      out  memory address
//   mem_data         io   bidirectional memory data bus
// ============================================================================
module slow_memory_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  mem_start,
  input  logic                  mem_rdy,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Request FIFO
  // --------------------------------------------------------------------------
  logic                  fifo_write [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t state;

  logic push;
  logic pop;
  logic fifo_empty;

  logic                  head_write;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  head_misaligned;

  // req_ready depends only on the registered count, so a pop in the current
  // cycle frees a slot for acceptance only from the next cycle on.
  assign req_ready  = (count != FULL_COUNT);
  assign fifo_empty = (count == '0);
  assign push       = req_valid && req_ready;
  assign pop        = (state == RESP) && resp_ready;

  assign head_write      = fifo_write[rd_ptr];
  assign head_addr       = fifo_addr[rd_ptr];
  assign head_wdata      = fifo_wdata[rd_ptr];
  assign head_misaligned = (head_addr[1:0] != 2'b00);

  // Payload storage needs no reset: count decides which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= req_write;
      fifo_addr[wr_ptr]  <= req_addr;
      fifo_wdata[wr_ptr] <= req_wdata;
    end
  end

  // Pointers are exactly log2(depth) bits wide, so the increment wraps
  // modulo the depth; the extra count bit tells full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered memory-side and response outputs
  // --------------------------------------------------------------------------
  logic [TMO_W-1:0]      tmo_count;
  logic                  drive_en;
  logic [DATA_WIDTH-1:0] wdata_out;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_err         <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      drive_en         <= 1'b0;
      wdata_out        <= '0;
      tmo_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            if (head_misaligned) begin
              // Reject without touching the memory.
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              // Latch the head onto the memory bus for ISSUE and WAIT.
              state            <= ISSUE;
              mem_address      <= head_addr;
              mem_write_enable <= head_write;
              drive_en         <= head_write;
              wdata_out        <= head_wdata;
            end
          end
        end

        ISSUE: begin
          if (mem_rdy) begin
            state     <= WAIT;
            tmo_count <= '0;
          end
        end

        WAIT: begin
          tmo_count <= tmo_count + 1'b1;
          if (mem_rdy) begin
            state            <= RESP;
            resp_valid       <= 1'b1;
            resp_err         <= 1'b0;
            resp_rdata       <= mem_write_enable ? '0 : mem_data;
            mem_address      <= '0;
            mem_write_enable <= 1'b0;
            drive_en         <= 1'b0;
          end else if (tmo_count == TMO_LAST) begin
            // This is the last allowed WAIT cycle and memory is still busy.
            state            <= RESP;
            resp_valid       <= 1'b1;
            resp_err         <= 1'b1;
            resp_rdata       <= '0;
            mem_address      <= '0;
            mem_write_enable <= 1'b0;
            drive_en         <= 1'b0;
          end
        end

        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // mem_start follows mem_rdy while in ISSUE only; reset forces IDLE, so it
  // drops together with the rest of the outputs.
  assign mem_start = (state == ISSUE) && mem_rdy;

  assign mem_data = drive_en ? wdata_out : {DATA_WIDTH{1'bz}};

endmodule

`default_nettype wire
